fft_frame_sched: RTL and testbench

FFT_FRAME_SCHED -- requirements
Module: fft_frame_sched

---
 rtl/fas_pkg.sv | 18 +
 rtl/fft_frame_bank.sv | 28 ++
 rtl/fft_frame_sched.sv | 159 +++++++++++++++
 tb/tb_fft_frame_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fas_pkg.sv
// Shared types and sizes for the FFT frame scheduler.
package fas_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int FRAME_LEN = 16;
  localparam int FRAME_W   = SAMPLE_W * FRAME_LEN;
  localparam int IDX_W     = $clog2(FRAME_LEN);

  // Launch FSM: IDLE waits for a full read bank, LAUNCH is the one-cycle
  // start pulse, WAIT holds the frame until the engine answers, FIN is terminal.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_FIN    = 2'd3
  } state_t;

endpackage

// File: rtl/fft_frame_bank.sv
// One 16-sample frame buffer: single write port, whole frame readable as a
// packed word with sample k on bits [16k+15:16k].
module fft_frame_bank
  import fas_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic [IDX_W-1:0]    idx,
  input  logic [SAMPLE_W-1:0] wdata,
  output logic [FRAME_W-1:0]  frame
);

  logic [SAMPLE_W-1:0] mem [FRAME_LEN];

  // Sample storage; contents are don't-care until a full frame is written.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  // Flatten the storage into the packed frame word.
  always_comb begin
    frame = '0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      frame[k*SAMPLE_W +: SAMPLE_W] = mem[k];
    end
  end

endmodule

// File: rtl/fft_frame_sched.sv
// Ping-pong frame scheduler between a FIR sample stream and an FFT engine.
// Optional watchdog on the WAIT state: define FFT_SCHED_WDOG_EN.
//
// Handshake: a sample is taken on any cycle with fir_valid=1 (no back-pressure;
// samples hitting a full bank are dropped and flagged on ovf). A frame is
// offered with a one-cycle fft_start pulse when fft_ready=1; fft_frame is held
// until the cycle in which fft_valid=1 is seen in WAIT, which frees the bank.
module fft_frame_sched
  import fas_pkg::*;
#(
  parameter int N_FRAMES = 64,
  parameter int TMO_CYC  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fir_valid,
  input  logic [SAMPLE_W-1:0] fir_d,
  input  logic                fft_ready,
  input  logic                fft_valid,
  output logic                fft_start,
  output logic [FRAME_W-1:0]  fft_frame,
  output logic [7:0]          frame_cnt,
  output logic                ovf,
  output logic                done,
`ifdef FFT_SCHED_WDOG_EN
  output logic                tmo,
`endif
  output state_t              dbg_state
);

  localparam logic [7:0]       N_LIM    = 8'(N_FRAMES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t             state, next_state;
  logic [1:0]         full;
  logic               wr_bank, rd_bank;
  logic [IDX_W-1:0]   wr_idx;
  logic [7:0]         fill_cnt;
  logic [7:0]         cnt_next;
  logic               in_wait, frame_ok, timeout, release_ev;
  logic               accepting, target_free, wr_en, drop;
  logic [FRAME_W-1:0] bank_frame [2];

  assign in_wait    = (state == S_WAIT);
  assign frame_ok   = in_wait && fft_valid;
  assign release_ev = frame_ok || timeout;
  assign cnt_next   = frame_cnt + 8'd1;

  // Stop taking samples once every scheduled frame has been filled. A bank
  // being released this cycle is free for the incoming sample.
  assign accepting   = fir_valid && (fill_cnt != N_LIM);
  assign target_free = !full[wr_bank] || (release_ev && (rd_bank == wr_bank));
  assign wr_en       = accepting && target_free;
  assign drop        = accepting && !target_free;

  assign dbg_state = state;

  fft_frame_bank u_bank0 (
    .clk   (clk),
    .we    (wr_en && (wr_bank == 1'b0)),
    .idx   (wr_idx),
    .wdata (fir_d),
    .frame (bank_frame[0])
  );

  fft_frame_bank u_bank1 (
    .clk   (clk),
    .we    (wr_en && (wr_bank == 1'b1)),
    .idx   (wr_idx),
    .wdata (fir_d),
    .frame (bank_frame[1])
  );

`ifdef FFT_SCHED_WDOG_EN
  localparam logic [7:0] WD_LIM = 8'(TMO_CYC - 1);
  logic [7:0] wd_cnt;

  // Give up on the engine after TMO_CYC cycles in WAIT without an answer.
  assign timeout = in_wait && !fft_valid && (wd_cnt == WD_LIM);

  // Watchdog counter runs only while waiting; tmo is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      tmo    <= 1'b0;
    end else begin
      wd_cnt <= (in_wait && !release_ev) ? wd_cnt + 8'd1 : 8'd0;
      if (timeout) tmo <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  // TMO_CYC only matters with the watchdog; keep it referenced.
  logic unused_tmo_cyc;
  assign unused_tmo_cyc = ^8'(TMO_CYC);
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (full[rd_bank] && fft_ready) next_state = S_LAUNCH;
      S_LAUNCH: next_state = S_WAIT;
      S_WAIT:   if (release_ev)
                  next_state = (frame_ok && (cnt_next == N_LIM)) ? S_FIN : S_IDLE;
      S_FIN:    next_state = S_FIN;
      default:  next_state = S_IDLE;
    endcase
  end

  // Bank bookkeeping, launch pulse, counters and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fft_start <= 1'b0;
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= '0;
      fill_cnt  <= '0;
      frame_cnt <= '0;
      ovf       <= 1'b0;
      done      <= 1'b0;
    end else begin
      fft_start <= (next_state == S_LAUNCH);
      if (release_ev) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if (wr_en) begin
        if (wr_idx == LAST_IDX) begin
          full[wr_bank] <= 1'b1;
          wr_idx        <= '0;
          wr_bank       <= ~wr_bank;
          fill_cnt      <= fill_cnt + 8'd1;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
      if (drop) ovf <= 1'b1;
      if (frame_ok) begin
        frame_cnt <= cnt_next;
        if (cnt_next == N_LIM) done <= 1'b1;
      end
    end
  end

  // The frame is only visible while it is owned by the engine.
  always_comb begin
    fft_frame = '0;
    if ((state == S_LAUNCH) || (state == S_WAIT)) fft_frame = bank_frame[rd_bank];
  end

endmodule

// File: tb/tb_fft_frame_sched.sv
// Self-checking bench for fft_frame_sched (built with N_FRAMES=4).
module tb_fft_frame_sched;
  import fas_pkg::*;

  localparam int NF = 4;
  localparam int PH_IDLE = 0, PH_LAUNCH = 1, PH_WAIT = 2, PH_FIN = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         fir_valid = 1'b0;
  logic [15:0]  fir_d = '0;
  logic         fft_ready = 1'b0;
  logic         drv_fv = 1'b0;
  logic         resp_valid = 1'b0;
  logic         resp_en = 1'b0;
  logic         fft_valid;
  logic         fft_start;
  logic [255:0] fft_frame;
  logic [7:0]   frame_cnt;
  logic         ovf, done;
  state_t       dbg_state;
`ifdef FFT_SCHED_WDOG_EN
  logic         tmo;
`endif

  assign fft_valid = drv_fv | resp_valid;

  fft_frame_sched #(.N_FRAMES(NF), .TMO_CYC(255)) dut (
    .clk       (clk),
    .rst       (rst),
    .fir_valid (fir_valid),
    .fir_d     (fir_d),
    .fft_ready (fft_ready),
    .fft_valid (fft_valid),
    .fft_start (fft_start),
    .fft_frame (fft_frame),
    .frame_cnt (frame_cnt),
    .ovf       (ovf),
    .done      (done),
`ifdef FFT_SCHED_WDOG_EN
    .tmo       (tmo),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Completed, unreleased frames in launch order; the front is the one the
  // engine sees. At most two can exist (two banks).
  logic [255:0] exp_q[$];
  logic [255:0] m_part = '0;
  int           m_widx = 0, m_filled = 0, m_ph = PH_IDLE, m_cnt = 0;
  bit           m_ovf = 0, m_done = 0;
  bit           m_rel, m_room, m_go;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      m_widx = 0; m_filled = 0; m_ph = PH_IDLE; m_cnt = 0; m_ovf = 0; m_done = 0;
    end else begin
      m_rel  = (m_ph == PH_WAIT) && fft_valid;
      m_go   = (m_ph == PH_IDLE) && (exp_q.size() > 0) && fft_ready;
      m_room = (exp_q.size() < 2) || m_rel;
      if (m_rel) begin
        void'(exp_q.pop_front());
        m_cnt++;
      end
      if (fir_valid && (m_filled < NF)) begin
        if (m_room) begin
          m_part[m_widx*16 +: 16] = fir_d;
          m_widx++;
          if (m_widx == 16) begin
            exp_q.push_back(m_part);
            m_widx = 0;
            m_filled++;
          end
        end else begin
          m_ovf = 1;
        end
      end
      case (m_ph)
        PH_IDLE:   if (m_go) m_ph = PH_LAUNCH;
        PH_LAUNCH: m_ph = PH_WAIT;
        PH_WAIT:   if (m_rel) begin
                     if (m_cnt == NF) begin m_ph = PH_FIN; m_done = 1; end
                     else m_ph = PH_IDLE;
                   end
        default:   ;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [255:0] e_frame;
  always @(negedge clk) begin
    e_frame = ((m_ph == PH_LAUNCH) || (m_ph == PH_WAIT)) ? exp_q[0] : '0;
    check("fft_start", fft_start, (m_ph == PH_LAUNCH));
    check("fft_frame", fft_frame, e_frame);
    check("frame_cnt", frame_cnt, m_cnt);
    check("ovf", ovf, m_ovf);
    check("done", done, m_done);
  end

  // ---------------- responder: fft_valid 5 cycles after each start ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      if (resp_en && fft_start) begin
        repeat (4) @(posedge clk);
        #1 resp_valid = 1'b1;
        @(posedge clk);
        #1 resp_valid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present inputs for the next rising edge, return 1 time unit after it.
  task automatic put(input logic fv, input logic [15:0] fd, input logic fr, input logic fval);
    fir_valid = fv; fir_d = fd; fft_ready = fr; drv_fv = fval;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    fir_valid = 0; fir_d = '0; fft_ready = 0; drv_fv = 0; resp_en = 0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not end, limit 2000000 required");
    $fatal(1);
  end

  // ---------------- scenarios ----------------
  initial begin
    // Reset state
    do_reset();
    check("rst_start", fft_start, 1'b0);
    check("rst_frame", fft_frame, 256'd0);
    check("rst_state", dbg_state, S_IDLE);

    // S1: 16 samples, start one cycle after the 16th edge
    for (int i = 0; i < 16; i++) put(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0);
    check("s1_no_early_start", fft_start, 1'b0);
    put(1'b0, '0, 1'b1, 1'b0);
    check("s1_start", fft_start, 1'b1);
    check("s1_frame_lo", fft_frame[15:0], 16'h0100);
    check("s1_frame_hi", fft_frame[255:240], 16'h010F);
    put(1'b0, '0, 1'b1, 1'b1);            // fft_valid in LAUNCH: ignored
    check("s1_launch_valid_ignored", frame_cnt, 8'd0);
    put(1'b0, '0, 1'b1, 1'b1);            // fft_valid in WAIT: completes
    check("s1_cnt", frame_cnt, 8'd1);
    check("s1_frame_cleared", fft_frame, 256'd0);

    // S2: not ready, 48 samples -> last 16 dropped, then bank 0 launched
    do_reset();
    for (int i = 0; i < 48; i++) put(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
    check("s2_ovf", ovf, 1'b1);
    check("s2_no_start", fft_start, 1'b0);
    put(1'b0, '0, 1'b1, 1'b0);
    check("s2_start", fft_start, 1'b1);
    check("s2_frame_lo", fft_frame[15:0], 16'h0200);
    check("s2_frame_hi", fft_frame[255:240], 16'h020F);
    put(1'b0, '0, 1'b1, 1'b0);
    put(1'b0, '0, 1'b1, 1'b1);
    put(1'b0, '0, 1'b1, 1'b0);
    check("s2_bank1_lo", fft_frame[15:0], 16'h0210);

    // S3: release coinciding with writes into / completion of the other bank
    do_reset();
    for (int i = 0; i < 32; i++) put(1'b1, 16'h0300 + 16'(i), 1'b0, 1'b0);
    put(1'b0, '0, 1'b1, 1'b0);
    put(1'b0, '0, 1'b1, 1'b0);
    put(1'b1, 16'h0320, 1'b1, 1'b1);      // write into the bank released now
    check("s3_no_drop_release", ovf, 1'b0);
    for (int i = 0; i < 14; i++) put(1'b1, 16'h0321 + 16'(i), 1'b1, 1'b0);
    put(1'b1, 16'h032F, 1'b1, 1'b1);      // 16th sample with fft_valid
    check("s3_no_drop_fill", ovf, 1'b0);
    check("s3_cnt", frame_cnt, 8'd2);
    put(1'b0, '0, 1'b1, 1'b0);
    check("s3_next_start", fft_start, 1'b1);
    check("s3_frame_lo", fft_frame[15:0], 16'h0320);
    check("s3_frame_hi", fft_frame[255:240], 16'h032F);

    // S4: N_FRAMES=4, 64 samples, answers after 5 cycles
    do_reset();
    resp_en = 1'b1;
    for (int i = 0; i < 64; i++) put(1'b1, 16'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 100 && !done; i++) put(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) put(1'b1, 16'($urandom), 1'b1, 1'b0);
    check("s4_cnt", frame_cnt, 8'd4);
    check("s4_done", done, 1'b1);
    check("s4_ovf", ovf, 1'b0);
    check("s4_fin_state", dbg_state, S_FIN);
    resp_en = 1'b0;

    // S5: reset while in WAIT
    do_reset();
    for (int i = 0; i < 16; i++) put(1'b1, 16'h0400 + 16'(i), 1'b1, 1'b0);
    put(1'b0, '0, 1'b1, 1'b0);
    put(1'b0, '0, 1'b1, 1'b0);
    put(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) put(1'b1, 16'h0410 + 16'(i), 1'b1, 1'b0);
    put(1'b0, '0, 1'b1, 1'b0);
    put(1'b0, '0, 1'b1, 1'b0);
    check("s5_in_wait", dbg_state, S_WAIT);
    check("s5_cnt_before", frame_cnt, 8'd1);
    #2 rst = 1'b0;
    #1;
    check("s5_rst_state", dbg_state, S_IDLE);
    check("s5_rst_cnt", frame_cnt, 8'd0);
    check("s5_rst_frame", fft_frame, 256'd0);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) put(1'b1, 16'h0500 + 16'(i), 1'b1, 1'b0);
    put(1'b0, '0, 1'b1, 1'b0);
    check("s5_start", fft_start, 1'b1);
    check("s5_first_sample", fft_frame[15:0], 16'h0500);

    // Random traffic against the model
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int c = 0; c < 600; c++)
        put($urandom_range(0, 3) != 0, 16'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
